// File: rtl/ipsmacge_pkg.sv
// Shared definitions for the MAC receive path: frame FSM encoding,
// per-frame status bit positions and default legal frame lengths.
package ipsmacge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    localparam int STA_RUNT  = 3;
    localparam int STA_GIANT = 2;
    localparam int STA_SEQ   = 1;
    localparam int STA_FIFO  = 0;

    localparam int DEF_MIN_LEN = 64;
    localparam int DEF_MAX_LEN = 1518;

endpackage

// File: rtl/ipsmacge_satcnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module ipsmacge_satcnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ipsmacge_rxfrmctl.sv
// Receive frame controller: enforces sop/eop ordering, measures and classifies
// frames, reacts to converter read errors and keeps good/bad/drop statistics.
module ipsmacge_rxfrmctl
    import ipsmacge_pkg::*;
#(
    parameter int MAC_DW  = 32,
    parameter int MAC_BW  = 2,
    parameter int MAC_EW  = 4,
    parameter int LEN_W   = 14,
    parameter int MIN_LEN = DEF_MIN_LEN,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = 32
) (
    input  logic              maclk,
    input  logic              marst_,
    input  logic [MAC_DW-1:0] ma_idat,
    input  logic [MAC_BW-1:0] ma_inob,
    input  logic              ma_ivld,
    input  logic              ma_isop,
    input  logic              ma_ieop,
    input  logic [MAC_EW-1:0] ma_ierr,
    input  logic              rxrderr,
    input  logic              rxen,
    input  logic              cnt_clr,
    output logic [MAC_DW-1:0] fo_dat,
    output logic [MAC_BW-1:0] fo_nob,
    output logic              fo_vld,
    output logic              fo_sop,
    output logic              fo_eop,
    output logic [MAC_EW-1:0] fo_err,
    output logic [3:0]        fo_sta,
    output logic [LEN_W-1:0]  fo_len,
    output logic              fo_abt,
    output logic [CNT_W-1:0]  cnt_good,
    output logic [CNT_W-1:0]  cnt_bad,
    output logic [CNT_W-1:0]  cnt_drop,
    output state_e            dbg_state_o
);

    // Stream contract (in and out): a beat transfers on every cycle where vld=1;
    // there is no ready, so one beat per cycle is always consumed or dropped.

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_e              state_q, state_d;
    logic                seq_pend_q, seq_pend_d;
    logic                fifo_pend_q, fifo_pend_d;
    logic                cur_seq_q, cur_fifo_q;
    logic [MAC_EW-1:0]   err_q;
    logic [LEN_W-1:0]    len_q;

    logic                fwd, start, abort, drop_st, stray, sop_rx, close, good;
    logic                seq_d, fifo_d;
    logic [MAC_EW-1:0]   err_d;
    logic [LEN_W-1:0]    beat_len, len_d;
    logic [LEN_W:0]      len_sum;
    logic [3:0]          sta_d;

    always_comb begin
        state_d = state_q;
        fwd     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        drop_st = 1'b0;
        case (state_q)
            ST_IDLE, ST_DROP: begin
                if (ma_ivld && ma_isop) begin
                    if (rxen) begin
                        fwd     = 1'b1;
                        start   = 1'b1;
                        state_d = ma_ieop ? ST_IDLE : ST_FRAME;
                    end else begin
                        drop_st = 1'b1;
                        state_d = ma_ieop ? ST_IDLE : ST_DROP;
                    end
                end else if ((state_q == ST_DROP) && ma_ivld && ma_ieop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FRAME: begin
                // A read error discards the coincident beat even if it carries eop.
                if (rxrderr) begin
                    abort   = 1'b1;
                    state_d = (ma_ivld && ma_ieop) ? ST_IDLE : ST_DROP;
                end else if (ma_ivld) begin
                    fwd     = 1'b1;
                    abort   = ma_isop;
                    start   = ma_isop;
                    state_d = ma_ieop ? ST_IDLE : ST_FRAME;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stray   = (state_q == ST_IDLE) && ma_ivld && !ma_isop;
        sop_rx  = (state_q != ST_FRAME) && ma_ivld && ma_isop;
        seq_pend_d  = sop_rx ? 1'b0 : (seq_pend_q | stray);
        fifo_pend_d = sop_rx ? 1'b0 : (fifo_pend_q | (rxrderr && (state_q != ST_FRAME)));

        beat_len = LEN_W'(ma_inob) + LEN_W'(1);
        len_sum  = {1'b0, len_q} + {1'b0, beat_len};
        if (start) begin
            len_d = beat_len;
        end else if (len_sum[LEN_W]) begin
            len_d = '1;
        end else begin
            len_d = len_sum[LEN_W-1:0];
        end

        // A frame opened from FRAME (missing eop) inherits no pending flags.
        seq_d  = start ? ((state_q != ST_FRAME) && seq_pend_q) : cur_seq_q;
        fifo_d = start ? ((state_q != ST_FRAME) && (fifo_pend_q || rxrderr)) : cur_fifo_q;
        err_d  = start ? ma_ierr : (err_q | ma_ierr);

        sta_d            = '0;
        sta_d[STA_RUNT]  = (len_d < MIN_L);
        sta_d[STA_GIANT] = (len_d > MAX_L);
        sta_d[STA_SEQ]   = seq_d;
        sta_d[STA_FIFO]  = fifo_d;

        close = fwd && ma_ieop;
        good  = (sta_d == '0) && (err_d == '0);
    end

    always_ff @(posedge maclk or negedge marst_) begin
        if (!marst_) begin
            state_q     <= ST_IDLE;
            seq_pend_q  <= 1'b0;
            fifo_pend_q <= 1'b0;
            cur_seq_q   <= 1'b0;
            cur_fifo_q  <= 1'b0;
            err_q       <= '0;
            len_q       <= '0;
            fo_dat      <= '0;
            fo_nob      <= '0;
            fo_vld      <= 1'b0;
            fo_sop      <= 1'b0;
            fo_eop      <= 1'b0;
            fo_err      <= '0;
            fo_sta      <= '0;
            fo_len      <= '0;
            fo_abt      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_pend_q  <= seq_pend_d;
            fifo_pend_q <= fifo_pend_d;
            if (fwd) begin
                len_q      <= len_d;
                err_q      <= err_d;
                cur_seq_q  <= seq_d;
                cur_fifo_q <= fifo_d;
            end
            fo_vld <= fwd;
            fo_dat <= fwd ? ma_idat : '0;
            fo_nob <= fwd ? ma_inob : '0;
            fo_sop <= fwd && ma_isop;
            fo_eop <= close;
            fo_err <= close ? err_d : '0;
            fo_sta <= close ? sta_d : '0;
            fo_len <= close ? len_d : '0;
            fo_abt <= abort;
        end
    end

    assign dbg_state_o = state_q;

    // An abort and a bad eop in the same cycle collapse into one increment.
    ipsmacge_satcnt #(.W(CNT_W)) u_cnt_good (
        .clk_i (maclk), .rst_ni (marst_), .inc_i (close && good),
        .clr_i (cnt_clr), .cnt_o (cnt_good)
    );

    ipsmacge_satcnt #(.W(CNT_W)) u_cnt_bad (
        .clk_i (maclk), .rst_ni (marst_), .inc_i (abort || (close && !good)),
        .clr_i (cnt_clr), .cnt_o (cnt_bad)
    );

    ipsmacge_satcnt #(.W(CNT_W)) u_cnt_drop (
        .clk_i (maclk), .rst_ni (marst_), .inc_i (drop_st),
        .clr_i (cnt_clr), .cnt_o (cnt_drop)
    );

endmodule

// File: tb/tb_ipsmacge_rxfrmctl.sv
// Directed bench for the receive frame controller with an expected-beat queue
// and an independent output monitor.
module tb_ipsmacge_rxfrmctl;
    import ipsmacge_pkg::*;

    // Expected-beat packing: {abt, vld, sop, eop, nob[1:0], dat[31:0], err[3:0], sta[3:0], len[13:0]}
    localparam int XW = 60;

    logic        maclk = 1'b0;
    logic        marst_ = 1'b0;
    logic [31:0] ma_idat = '0;
    logic [1:0]  ma_inob = '0;
    logic        ma_ivld = 1'b0;
    logic        ma_isop = 1'b0;
    logic        ma_ieop = 1'b0;
    logic [3:0]  ma_ierr = '0;
    logic        rxrderr = 1'b0;
    logic        rxen = 1'b1;
    logic        cnt_clr = 1'b0;
    logic [31:0] fo_dat;
    logic [1:0]  fo_nob;
    logic        fo_vld, fo_sop, fo_eop, fo_abt;
    logic [3:0]  fo_err, fo_sta;
    logic [13:0] fo_len;
    logic [3:0]  cnt_good, cnt_bad, cnt_drop;
    state_e      dbg_state;

    logic [XW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    ipsmacge_rxfrmctl #(.CNT_W(4)) dut (
        .maclk (maclk), .marst_ (marst_),
        .ma_idat (ma_idat), .ma_inob (ma_inob), .ma_ivld (ma_ivld),
        .ma_isop (ma_isop), .ma_ieop (ma_ieop), .ma_ierr (ma_ierr),
        .rxrderr (rxrderr), .rxen (rxen), .cnt_clr (cnt_clr),
        .fo_dat (fo_dat), .fo_nob (fo_nob), .fo_vld (fo_vld),
        .fo_sop (fo_sop), .fo_eop (fo_eop), .fo_err (fo_err),
        .fo_sta (fo_sta), .fo_len (fo_len), .fo_abt (fo_abt),
        .cnt_good (cnt_good), .cnt_bad (cnt_bad), .cnt_drop (cnt_drop),
        .dbg_state_o (dbg_state)
    );

    always #5 maclk = ~maclk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void push_exp(input logic abt, input logic vld, input logic sop,
                                     input logic eop, input logic [1:0] nob,
                                     input logic [31:0] dat, input logic [3:0] err,
                                     input logic [3:0] sta, input logic [13:0] len);
        exp_q.push_back({abt, vld, sop, eop, nob, dat, err, sta, len});
    endfunction

    task automatic drive(input logic sop, input logic eop, input logic [1:0] nob,
                         input logic [31:0] dat, input logic [3:0] err,
                         input logic rderr, input logic clr);
        ma_ivld = 1'b1;
        ma_isop = sop;
        ma_ieop = eop;
        ma_inob = nob;
        ma_idat = dat;
        ma_ierr = err;
        rxrderr = rderr;
        cnt_clr = clr;
        @(posedge maclk);
        #1;
        ma_ivld = 1'b0;
        ma_isop = 1'b0;
        ma_ieop = 1'b0;
        ma_ierr = '0;
        rxrderr = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic idle(input int n, input logic rderr, input logic clr);
        for (int i = 0; i < n; i++) begin
            rxrderr = rderr;
            cnt_clr = clr;
            @(posedge maclk);
            #1;
            rxrderr = 1'b0;
            cnt_clr = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] fid, input int nb, input logic [1:0] last_nob,
                              input logic en, input logic en_mid, input logic fwd,
                              input logic abt_first, input logic [13:0] xlen,
                              input logic [3:0] xsta, input int err_beat,
                              input logic [3:0] xerr, input logic clr_last);
        logic s, e;
        logic [1:0] nob;
        logic [31:0] dat;
        for (int i = 0; i < nb; i++) begin
            s   = (i == 0);
            e   = (i == nb - 1);
            nob = e ? last_nob : 2'd3;
            dat = {fid, 16'(i)};
            rxen = s ? en : en_mid;
            if (fwd)
                push_exp(s & abt_first, 1'b1, s, e, nob, dat,
                         e ? xerr : 4'h0, e ? xsta : 4'h0, e ? xlen : 14'd0);
            drive(s, e, nob, dat, (i == err_beat) ? 4'h2 : 4'h0, 1'b0, e & clr_last);
        end
    endtask

    // Output monitor: every presented beat or abort pulse must match the queue head.
    initial begin
        logic [XW-1:0] got, exp;
        forever begin
            @(negedge maclk);
            if (fo_vld || fo_abt) begin
                got = {fo_abt, fo_vld, fo_sop, fo_eop, fo_nob, fo_dat, fo_err, fo_sta, fo_len};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_out: got %h expected nothing", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (!exp[58]) begin
                        if (got[59:58] !== exp[59:58]) begin
                            n_mis++;
                            $display("FAIL abort_pulse: got abt/vld %b expected %b", got[59:58], exp[59:58]);
                        end
                    end else if (got !== exp) begin
                        n_mis++;
                        $display("FAIL out_beat: got %h expected %h", got, exp);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge maclk);
        #1;
        chk("rst_vld", 32'(fo_vld), 32'd0);
        chk("rst_abt", 32'(fo_abt), 32'd0);
        chk("rst_len", 32'(fo_len), 32'd0);
        chk("rst_good", 32'(cnt_good), 32'd0);
        chk("rst_bad", 32'(cnt_bad), 32'd0);
        chk("rst_drop", 32'(cnt_drop), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        marst_ = 1'b1;
        idle(2, 1'b0, 1'b0);

        // 64-byte good frame
        send_frame(16'h0001, 16, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 14'd64, 4'b0000, -1, 4'h0, 1'b0);
        chk("good_64", 32'(cnt_good), 32'd1);

        // 61-byte runt, then 1522-byte giant (380 full beats + 2 bytes), back to back
        send_frame(16'h0002, 16, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd61, 4'b1000, -1, 4'h0, 1'b0);
        chk("bad_runt", 32'(cnt_bad), 32'd1);
        send_frame(16'h0003, 381, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 14'd1522, 4'b0100, -1, 4'h0, 1'b0);
        chk("bad_giant", 32'(cnt_bad), 32'd2);
        chk("good_after_giant", 32'(cnt_good), 32'd1);

        idle(1, 1'b0, 1'b1);
        chk("clr_good", 32'(cnt_good), 32'd0);
        chk("clr_bad", 32'(cnt_bad), 32'd0);

        // Missing eop: sop arrives at beat 5 of an open frame
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 1'b1, i == 0, 1'b0, 2'd3, {16'h0004, 16'(i)}, 4'h0, 4'h0, 14'd0);
            drive(i == 0, 1'b0, 2'd3, {16'h0004, 16'(i)}, 4'h0, 1'b0, 1'b0);
        end
        send_frame(16'h0005, 16, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 14'd64, 4'b0000, -1, 4'h0, 1'b0);
        chk("noeop_bad", 32'(cnt_bad), 32'd1);
        chk("noeop_good", 32'(cnt_good), 32'd1);

        // Read error at beat 3 of 16: beats 3..16 suppressed, abort without vld
        for (int i = 0; i < 16; i++) begin
            if (i < 2)
                push_exp(1'b0, 1'b1, i == 0, 1'b0, 2'd3, {16'h0006, 16'(i)}, 4'h0, 4'h0, 14'd0);
            else if (i == 2)
                push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 4'h0, 4'h0, 14'd0);
            drive(i == 0, i == 15, 2'd3, {16'h0006, 16'(i)}, 4'h0, i == 2, 1'b0);
        end
        chk("rderr_bad", 32'(cnt_bad), 32'd2);
        send_frame(16'h0007, 16, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 14'd64, 4'b0000, -1, 4'h0, 1'b0);
        chk("rderr_next_good", 32'(cnt_good), 32'd2);

        // Stray beat in IDLE marks the next frame with seqerr
        drive(1'b0, 1'b0, 2'd3, 32'hdead_beef, 4'h0, 1'b0, 1'b0);
        send_frame(16'h0008, 16, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 14'd64, 4'b0010, -1, 4'h0, 1'b0);
        chk("seqerr_bad", 32'(cnt_bad), 32'd3);

        // Read error while idle marks the next frame with fifoerr
        idle(1, 1'b1, 1'b0);
        send_frame(16'h0009, 16, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 14'd64, 4'b0001, -1, 4'h0, 1'b0);
        chk("fifoerr_bad", 32'(cnt_bad), 32'd4);

        // Per-beat error ORed into the eop
        send_frame(16'h000a, 16, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 14'd64, 4'b0000, 5, 4'h2, 1'b0);
        chk("ierr_bad", 32'(cnt_bad), 32'd5);

        // rxen low at sop of A drops all of A; clearing rxen inside B keeps B whole
        send_frame(16'h000b, 16, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0, 4'b0000, -1, 4'h0, 1'b0);
        send_frame(16'h000c, 16, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 14'd64, 4'b0000, -1, 4'h0, 1'b0);
        rxen = 1'b1;
        chk("drop_cnt", 32'(cnt_drop), 32'd1);
        chk("rxen_good", 32'(cnt_good), 32'd3);

        // Abort plus runt eop in the same cycle count as one bad
        idle(1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, 1'b1, i == 0, 1'b0, 2'd3, {16'h000d, 16'(i)}, 4'h0, 4'h0, 14'd0);
            drive(i == 0, 1'b0, 2'd3, {16'h000d, 16'(i)}, 4'h0, 1'b0, 1'b0);
        end
        send_frame(16'h000e, 1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 14'd4, 4'b1000, -1, 4'h0, 1'b0);
        chk("double_bad", 32'(cnt_bad), 32'd1);

        // Saturation with 4-bit counters, then clear coincident with a good eop
        idle(1, 1'b0, 1'b1);
        for (int k = 0; k < 17; k++)
            send_frame(16'h0100 + 16'(k), 16, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 14'd64, 4'b0000, -1, 4'h0, 1'b0);
        chk("good_sat", 32'(cnt_good), 32'd15);
        send_frame(16'h0200, 16, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 14'd64, 4'b0000, -1, 4'h0, 1'b1);
        chk("clr_wins", 32'(cnt_good), 32'd0);

        idle(4, 1'b0, 1'b0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
